jt6295_cmd_seq: RTL and testbench

Command sequencer for the JT6295 ADPCM core. It sits between the CPU write port and the four-channel serial playback engine. It decodes the two-byte MSM6295 play command and the one-byte stop command, and fetches the phrase start/stop addresses from the ROM header. It then launches each requested idle channel in that channel's time slot, in lock-step with the engine's channel rotation.

---
 rtl/jt6295_cmd_seq.sv | 126 ++++++++++++
 tb/tb_jt6295_cmd_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jt6295_cmd_seq.sv
// MSM6295 command sequencer: decodes CPU play/stop bytes, fetches the phrase
// header from ROM and launches idle channels in step with the engine's slot rotation.
module jt6295_cmd_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        wrn,
  input  logic [7:0]  din,
  input  logic [3:0]  busy,
  output logic [17:0] start_addr,
  output logic [17:0] stop_addr,
  output logic [3:0]  att,
  output logic [3:0]  start,
  output logic [3:0]  stop,
  output logic        rom_cs,
  output logic [9:0]  rom_addr,
  input  logic [7:0]  rom_data,
  input  logic        rom_ok,
  output logic        cmd_busy
);

  typedef enum logic [1:0] {IDLE, ARMED, FETCH, LAUNCH} state_t;

  state_t     state;
  logic       wrn_l;
  logic       wr_ev;
  logic       addr_wait;
  logic [6:0] phrase;
  logic [3:0] mask;
  logic [3:0] mask_in;
  logic [3:0] slot;
  logic [2:0] k;

  assign wr_ev   = wrn_l & ~wrn;
  assign mask_in = din[7:4] & ~busy;

  // The engine samples start on the clk cycles between its enables.
  assign start = (state == LAUNCH && !cen) ? (mask & slot) : 4'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wrn_l      <= 1'b1;
      addr_wait  <= 1'b0;
      phrase     <= 7'd0;
      mask       <= 4'd0;
      slot       <= 4'b0001;
      k          <= 3'd0;
      start_addr <= 18'd0;
      stop_addr  <= 18'd0;
      att        <= 4'd0;
      stop       <= 4'd0;
      rom_cs     <= 1'b0;
      rom_addr   <= 10'd0;
      cmd_busy   <= 1'b0;
    end else begin
      wrn_l <= wrn;
      if (cen) begin
        slot <= {slot[2:0], slot[3]};
        stop <= 4'd0;
      end
      case (state)
        IDLE: begin
          if (wr_ev) begin
            if (din[7]) begin
              phrase <= din[6:0];
              state  <= ARMED;
            end else begin
              stop <= din[6:3];
            end
          end
        end
        ARMED: begin
          if (wr_ev) begin
            att  <= din[3:0];
            mask <= mask_in;
            if (phrase == 7'd0 || mask_in == 4'd0) begin
              state <= IDLE;
            end else begin
              state     <= FETCH;
              cmd_busy  <= 1'b1;
              rom_cs    <= 1'b1;
              rom_addr  <= {phrase, 3'b000};
              k         <= 3'd0;
              addr_wait <= 1'b1;
            end
          end
        end
        FETCH: begin
          // rom_ok in the first cycle of a new address still belongs to the old one.
          if (addr_wait) begin
            addr_wait <= 1'b0;
          end else if (rom_ok) begin
            case (k)
              3'd0:    start_addr[17:16] <= rom_data[1:0];
              3'd1:    start_addr[15:8]  <= rom_data;
              3'd2:    start_addr[7:0]   <= rom_data;
              3'd3:    stop_addr[17:16]  <= rom_data[1:0];
              3'd4:    stop_addr[15:8]   <= rom_data;
              default: stop_addr[7:0]    <= rom_data;
            endcase
            if (k == 3'd5) begin
              rom_cs <= 1'b0;
              state  <= LAUNCH;
            end else begin
              k         <= k + 3'd1;
              rom_addr  <= rom_addr + 10'd1;
              addr_wait <= 1'b1;
            end
          end
        end
        LAUNCH: begin
          if (cen && (mask & slot) != 4'd0) begin
            mask <= mask & ~slot;
            if ((mask & ~slot) == 4'd0) begin
              state    <= IDLE;
              cmd_busy <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jt6295_cmd_seq.sv
// Bench for jt6295_cmd_seq: random enables, stalling header ROM model and a
// slot-counting launch model checked with immediate assertions.
module tb_jt6295_cmd_seq;

  logic        clk = 1'b0, rst = 1'b1, cen = 1'b0, wrn = 1'b1;
  logic [7:0]  din = 8'd0, rom_data = 8'd0;
  logic [3:0]  busy = 4'd0;
  logic        rom_ok = 1'b0;
  logic [17:0] start_addr, stop_addr;
  logic [3:0]  att, start, stop;
  logic        rom_cs, cmd_busy;
  logic [9:0]  rom_addr;

  int errors = 0, checks = 0;
  logic [7:0]  hdr [0:1023];
  int          slot_idx;
  logic [3:0]  slot_exp;
  logic [3:0]  pending = 4'd0, launched = 4'd0;
  logic [17:0] exp_start = 18'd0, exp_stop = 18'd0;
  logic [9:0]  exp_base = 10'd0, last_addr = 10'd0;
  logic        last_cs = 1'b0, stop_test = 1'b0;
  int          nchg = 0, stall = 0;

  jt6295_cmd_seq dut (
    .clk(clk), .rst(rst), .cen(cen), .wrn(wrn), .din(din), .busy(busy),
    .start_addr(start_addr), .stop_addr(stop_addr), .att(att), .start(start),
    .stop(stop), .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data),
    .rom_ok(rom_ok), .cmd_busy(cmd_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Engine channel pointer: advances once per enable.
  always @(posedge clk or posedge rst)
    if (rst) slot_idx <= 0;
    else if (cen) slot_idx <= (slot_idx + 1) % 4;
  assign slot_exp = 4'b0001 << slot_idx;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (cen) cen = 1'b0;
      else cen = ($urandom_range(0, 2) == 0);
    end
  end

  // Header ROM: stale (inverted) data on the first cycle of an address, then 0-5 stall cycles.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rom_cs && (!last_cs || rom_addr != last_addr)) begin
        if (!last_cs) begin
          nchg = 0;
          check("rom_base", 32'(rom_addr), 32'(exp_base));
        end else begin
          nchg++;
          check("rom_step", 32'(rom_addr), 32'(exp_base) + 32'(nchg));
        end
        rom_data = ~hdr[rom_addr];
        rom_ok   = 1'($urandom_range(0, 1));
        stall    = $urandom_range(0, 5);
      end else if (rom_cs) begin
        if (stall > 0) begin
          rom_ok   = 1'b0;
          rom_data = 8'($urandom);
          stall--;
        end else begin
          rom_ok   = 1'b1;
          rom_data = hdr[rom_addr];
        end
      end else begin
        rom_ok = 1'b0;
      end
      last_addr = rom_addr;
      last_cs   = rom_cs;
    end
  end

  // Launch phase = cmd_busy with the fetch finished.
  always @(negedge clk) begin
    if (!rst) begin
      if (!stop_test) check("stop_quiet", 32'(stop), 32'd0);
      if (cmd_busy && !rom_cs) begin
        check("hold_start_addr", 32'(start_addr), 32'(exp_start));
        check("hold_stop_addr", 32'(stop_addr), 32'(exp_stop));
        if (cen) begin
          check("start_on_cen", 32'(start), 32'd0);
          if ((pending & slot_exp) != 4'd0) begin
            launched = launched | slot_exp;
            pending  = pending & ~slot_exp;
          end
        end else begin
          check("start_vec", 32'(start), 32'(pending & slot_exp));
        end
      end else begin
        check("start_idle", 32'(start), 32'd0);
      end
    end
  end

  task automatic wr(input logic [7:0] b, input logic [3:0] bz);
    @(negedge clk); din = b; busy = bz; wrn = 1'b0;
    @(negedge clk); wrn = 1'b1; busy = 4'($urandom);
  endtask

  task automatic arm_fetch(input logic [6:0] ph, input logic [7:0] mb, input logic [3:0] bz,
                           input bit drop_wr, output bit go, output int ncen);
    logic [3:0] m;
    int cyc;
    bit cs_seen;
    m         = mb[7:4] & ~bz;
    exp_base  = {ph, 3'b000};
    exp_start = {hdr[exp_base][1:0], hdr[exp_base + 10'd1], hdr[exp_base + 10'd2]};
    exp_stop  = {hdr[exp_base + 10'd3][1:0], hdr[exp_base + 10'd4], hdr[exp_base + 10'd5]};
    launched  = 4'd0;
    pending   = 4'd0;
    ncen      = 0;
    wr({1'b1, ph}, bz);
    check("armed_not_busy", 32'(cmd_busy), 32'd0);
    wr(mb, bz);
    check("att", 32'(att), 32'(mb[3:0]));
    go = (ph != 7'd0) && (m != 4'd0);
    if (!go) begin
      cs_seen = 1'b0;
      repeat (20) begin
        @(negedge clk);
        cs_seen = cs_seen | rom_cs | cmd_busy;
      end
      check("no_fetch", 32'(cs_seen), 32'd0);
    end else begin
      check("cmd_busy_set", 32'(cmd_busy), 32'd1);
      check("rom_cs_set", 32'(rom_cs), 32'd1);
      pending = m;
      if (drop_wr) wr(8'h78, bz);
      cyc = 0;
      while (rom_cs && cyc < 300) begin
        @(negedge clk);
        cyc++;
      end
      check("fetch_done", 32'(rom_cs), 32'd0);
      if (!drop_wr) check("fetch_len_min", 32'(cyc >= 12), 32'd1);
      check("rom_last_step", 32'(nchg), 32'd5);
      check("start_addr", 32'(start_addr), 32'(exp_start));
      check("stop_addr", 32'(stop_addr), 32'(exp_stop));
      if (cen && cmd_busy) ncen = 1;
    end
  endtask

  task automatic play(input logic [6:0] ph, input logic [7:0] mb, input logic [3:0] bz, input bit drop_wr);
    logic [3:0] m;
    bit go;
    int ncen, cyc;
    m = mb[7:4] & ~bz;
    arm_fetch(ph, mb, bz, drop_wr, go, ncen);
    if (go) begin
      cyc = 0;
      while (cmd_busy && cyc < 300) begin
        @(negedge clk);
        cyc++;
        if (cen && cmd_busy) ncen++;
      end
      check("launch_done", 32'(cmd_busy), 32'd0);
      check("launched", 32'(launched), 32'(m));
      check("launch_latency", 32'(ncen <= 4 * $countones(m)), 32'd1);
      check("att_after", 32'(att), 32'(mb[3:0]));
    end
    $display("play phrase=%0d mask_byte=%02h busy=%b launched=%b start_addr=%05h stop_addr=%05h att=%0h cens=%0d",
             ph, mb, bz, launched, start_addr, stop_addr, att, ncen);
  endtask

  initial begin
    int cyc;
    bit go;
    int ncen;
    for (int i = 0; i < 1024; i++) hdr[i] = 8'($urandom);
    hdr[8] = 8'h01; hdr[9] = 8'h23; hdr[10] = 8'h45;
    hdr[11] = 8'h02; hdr[12] = 8'h34; hdr[13] = 8'h56;
    hdr[400] = 8'hFF; hdr[401] = 8'hFF; hdr[402] = 8'hFF;
    hdr[403] = 8'hFC; hdr[404] = 8'h00; hdr[405] = 8'h01;

    repeat (3) @(negedge clk);
    check("rst_start_addr", 32'(start_addr), 32'd0);
    check("rst_stop_addr", 32'(stop_addr), 32'd0);
    check("rst_att", 32'(att), 32'd0);
    check("rst_start", 32'(start), 32'd0);
    check("rst_stop", 32'(stop), 32'd0);
    check("rst_rom_cs", 32'(rom_cs), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_cmd_busy", 32'(cmd_busy), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    play(7'd1, 8'h1A, 4'b0000, 1'b0);
    check("tp1_start_addr", 32'(start_addr), 32'h12345);
    check("tp1_stop_addr", 32'(stop_addr), 32'h23456);
    play(7'd9, 8'hF0, 4'b0100, 1'b0);

    // Stop byte in IDLE: held through the first enable, cleared the clk after.
    @(negedge clk); din = 8'h28; wrn = 1'b0; stop_test = 1'b1;
    @(negedge clk); wrn = 1'b1;
    check("stop_set", 32'(stop), 32'b0101);
    check("stop_state_idle", 32'(cmd_busy), 32'd0);
    cyc = 0;
    while (!cen && cyc < 50) begin
      @(negedge clk);
      cyc++;
      check("stop_hold", 32'(stop), 32'b0101);
    end
    @(negedge clk);
    check("stop_clear", 32'(stop), 32'd0);
    stop_test = 1'b0;
    $display("stop byte=28 cens_waited=%0d", cyc);

    play(7'd0, 8'hF5, 4'b0000, 1'b0);
    play(7'd20, 8'h37, 4'b1111, 1'b0);
    play(7'd127, 8'hF6, 4'b0000, 1'b1);
    play(7'd3, 8'h28, 4'b0000, 1'b0);
    play(7'd50, 8'h9C, 4'b0000, 1'b0);
    check("rev_start_addr", 32'(start_addr), 32'h3FFFF);
    check("rev_stop_addr", 32'(stop_addr), 32'h00001);

    for (int t = 0; t < 10; t++)
      play(7'($urandom_range(1, 127)), 8'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));

    // Reset in the middle of a launch.
    arm_fetch(7'd5, 8'hC3, 4'b0000, 1'b0, go, ncen);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    check("mid_rst_start", 32'(start), 32'd0);
    check("mid_rst_stop", 32'(stop), 32'd0);
    check("mid_rst_rom_cs", 32'(rom_cs), 32'd0);
    check("mid_rst_rom_addr", 32'(rom_addr), 32'd0);
    check("mid_rst_cmd_busy", 32'(cmd_busy), 32'd0);
    check("mid_rst_start_addr", 32'(start_addr), 32'd0);
    check("mid_rst_stop_addr", 32'(stop_addr), 32'd0);
    check("mid_rst_att", 32'(att), 32'd0);
    pending = 4'd0;
    @(negedge clk); rst = 1'b0;
    repeat (40) @(negedge clk);
    check("post_rst_idle", 32'(cmd_busy), 32'd0);
    $display("reset during launch phrase=5 mask=1100 launched_before_rst=%b", launched);

    play(7'd2, 8'hF1, 4'b0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
